sdram_cpu_bridge: RTL

Upstream neighbour of the SDRAM/VGA memory controller. It turns CPU byte and word requests (x86 little-endian, any alignment) into the controller's byte-wide interface. That interface starts a transaction only when its address input changes and signals completion through a level ready. The bridge handles the same-address case with a one-byte shadow register or a dummy access, and gives the CPU a clean req/done handshake with a timeout.

---
 rtl/sdram_cpu_bridge_pkg.sv | 24 ++
 rtl/sdram_byte_issuer.sv | 85 ++++++++
 rtl/sdram_cpu_bridge.sv | 139 +++++++++++++
 3 files changed

// File: rtl/sdram_cpu_bridge_pkg.sv
// Shared types for the CPU-to-SDRAM byte bridge: top-level sequencer states,
// byte-issuer phases and the default address width.
package sdram_cpu_bridge_pkg;
  localparam int ADDR_W_DEFAULT = 26;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DECIDE,
    S_DUMMY_GUARD,
    S_DUMMY_WAIT,
    S_ISSUE,
    S_SHADOW,
    S_GUARD,
    S_WAIT,
    S_NEXT,
    S_DONE
  } bridge_state_t;

  typedef enum logic [1:0] {
    P_IDLE,
    P_GUARD,
    P_WAIT
  } issue_phase_t;
endpackage

// File: rtl/sdram_byte_issuer.sv
// Issues one byte access to the controller: latch address/we/data, ignore the
// stale ready level for a few cycles, then wait for ready or time out.
module sdram_byte_issuer
  import sdram_cpu_bridge_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEFAULT,
  parameter int GUARD_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [7:0]        wdata,
  input  logic              mem_ready,
  input  logic [7:0]        mem_q,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_we,
  output logic [7:0]        mem_data,
  output logic              guarding,
  output logic              done,
  output logic              timeout,
  output logic [7:0]        q
);
  localparam int GW = $clog2(GUARD_CYCLES + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES > 0 ? GUARD_CYCLES - 1 : 0);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  issue_phase_t  phase;
  logic [GW-1:0] guard_cnt;
  logic [TW-1:0] tmo_cnt;

  assign guarding = (phase == P_GUARD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase       <= P_IDLE;
      guard_cnt   <= '0;
      tmo_cnt     <= '0;
      mem_address <= '0;
      mem_we      <= 1'b0;
      mem_data    <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      q           <= '0;
    end else begin
      done <= 1'b0;
      case (phase)
        P_IDLE: begin
          if (start) begin
            mem_address <= addr;
            mem_we      <= we;
            mem_data    <= wdata;
            guard_cnt   <= '0;
            tmo_cnt     <= '0;
            phase       <= (GUARD_CYCLES > 0) ? P_GUARD : P_WAIT;
          end
        end
        // The timeout budget spans guard and wait together.
        P_GUARD: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (guard_cnt == GUARD_LAST) phase <= P_WAIT;
          else guard_cnt <= guard_cnt + 1'b1;
        end
        P_WAIT: begin
          if (mem_ready) begin
            done    <= 1'b1;
            timeout <= 1'b0;
            q       <= mem_q;
            phase   <= P_IDLE;
          end else if (tmo_cnt >= TMO_LAST) begin
            done    <= 1'b1;
            timeout <= 1'b1;
            phase   <= P_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: phase <= P_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/sdram_cpu_bridge.sv
// Splits CPU byte/word requests into byte accesses on a controller that only
// starts on an address change; same-address cases use a shadow byte or a dummy read.
module sdram_cpu_bridge
  import sdram_cpu_bridge_pkg::*;
#(
  parameter int GUARD_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ADDR_W         = ADDR_W_DEFAULT
) (
  input  logic              clock_100_mhz,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_wide,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [15:0]       cpu_wdata,
  output logic [15:0]       cpu_rdata,
  output logic              cpu_busy,
  output logic              cpu_done,
  output logic              cpu_error,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_we,
  output logic [7:0]        mem_data,
  input  logic [7:0]        mem_q,
  input  logic              mem_ready
);
  bridge_state_t     state;
  logic              req_we, req_wide, byte_idx;
  logic [ADDR_W-1:0] req_addr, last_addr;
  logic [15:0]       req_wdata;
  logic [7:0]        shadow, res_lo, res_hi;
  logic              shadow_valid, unsynced;

  logic [ADDR_W-1:0] target, iss_addr;
  logic [7:0]        wbyte, iss_q;
  logic              shadow_hit, need_dummy, iss_start, iss_we;
  logic              iss_guarding, iss_done, iss_timeout;

  assign target     = byte_idx ? req_addr + 1'b1 : req_addr;
  assign wbyte      = byte_idx ? req_wdata[15:8] : req_wdata[7:0];
  assign shadow_hit = (target == last_addr) && !req_we && shadow_valid;
  assign need_dummy = unsynced || (target == last_addr);
  // The dummy read goes to the neighbouring byte so the address latch moves.
  assign iss_start  = (state == S_ISSUE) || (state == S_DECIDE && !shadow_hit && need_dummy);
  assign iss_addr   = (state == S_ISSUE) ? target : {target[ADDR_W-1:1], ~target[0]};
  assign iss_we     = (state == S_ISSUE) && req_we;

  sdram_byte_issuer #(
    .ADDR_W(ADDR_W), .GUARD_CYCLES(GUARD_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_issuer (
    .clk(clock_100_mhz), .rst_n(reset_n), .start(iss_start), .addr(iss_addr),
    .we(iss_we), .wdata(wbyte), .mem_ready(mem_ready), .mem_q(mem_q),
    .mem_address(mem_address), .mem_we(mem_we), .mem_data(mem_data),
    .guarding(iss_guarding), .done(iss_done), .timeout(iss_timeout), .q(iss_q)
  );

  always_ff @(posedge clock_100_mhz or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      {req_we, req_wide, byte_idx} <= '0;
      req_addr <= '0;
      req_wdata <= '0;
      last_addr <= '0;
      {shadow, res_lo, res_hi} <= '0;
      shadow_valid <= 1'b0;
      unsynced <= 1'b1;
      cpu_rdata <= '0;
      cpu_busy <= 1'b0;
      cpu_done <= 1'b0;
      cpu_error <= 1'b0;
    end else if ((state == S_DUMMY_WAIT || state == S_WAIT) && iss_done && iss_timeout) begin
      shadow_valid <= 1'b0;
      unsynced <= 1'b1;
      cpu_done <= 1'b1;
      cpu_error <= 1'b1;
      state <= S_DONE;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_req) begin
            req_we <= cpu_we;
            req_wide <= cpu_wide;
            req_addr <= cpu_address;
            req_wdata <= cpu_wdata;
            byte_idx <= 1'b0;
            cpu_busy <= 1'b1;
            state <= S_DECIDE;
          end
        end
        S_DECIDE: begin
          if (shadow_hit) begin
            if (byte_idx) res_hi <= shadow;
            else res_lo <= shadow;
            state <= S_SHADOW;
          end else if (need_dummy) begin
            last_addr <= iss_addr;
            state <= S_DUMMY_GUARD;
          end else begin
            state <= S_ISSUE;
          end
        end
        S_DUMMY_GUARD: if (!iss_guarding) state <= S_DUMMY_WAIT;
        S_DUMMY_WAIT:  if (iss_done) state <= S_ISSUE;
        S_ISSUE: begin
          last_addr <= target;
          state <= S_GUARD;
        end
        S_GUARD: if (!iss_guarding) state <= S_WAIT;
        S_WAIT: begin
          if (iss_done) begin
            if (!req_we && byte_idx) res_hi <= iss_q;
            if (!req_we && !byte_idx) res_lo <= iss_q;
            shadow <= req_we ? wbyte : iss_q;
            shadow_valid <= 1'b1;
            unsynced <= 1'b0;
            state <= S_NEXT;
          end
        end
        S_SHADOW, S_NEXT: begin
          if (req_wide && !byte_idx) begin
            byte_idx <= 1'b1;
            state <= S_DECIDE;
          end else begin
            cpu_done <= 1'b1;
            cpu_error <= 1'b0;
            cpu_rdata <= {req_wide ? res_hi : 8'h00, res_lo};
            state <= S_DONE;
          end
        end
        S_DONE: begin
          cpu_done <= 1'b0;
          cpu_busy <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
